hcb_frame_sequencer: RTL and testbench

- Sequences one AXI-Stream frame of PACKETS_NUM beats into the HCB clause-computation chain.
- For each accepted beat it registers the data onto the shared x bus and pulses the matching one-hot valid bit, so chain stage k latches packet k.
- After the last stage settles, it captures the final partial_clause vector and offers it downstream with a valid/ready handshake.
- It also detects malformed frames (tlast early or missing) and keeps such frames out of the chain.

---
 rtl/hcb_frame_sequencer.sv | 121 ++++++++++++
 tb/tb_hcb_frame_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hcb_frame_sequencer.sv
// hcb_frame_sequencer: feeds one AXI-Stream frame of PACKETS_NUM beats into the HCB chain and hands off the final clause.
// Defining HCB_SEQ_PERF_EN adds the frame_cnt/stall_cnt performance counter ports.
module hcb_frame_sequencer #(
    parameter int PACKETS_NUM = 13,
    parameter int CLAUSE_NUM = 200,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int PIPE_LAT = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0] x,
    output logic [PACKETS_NUM-1:0]            valid,
    input  logic [CLAUSE_NUM-1:0]             partial_clause,
    output logic [CLAUSE_NUM-1:0]             clause_out,
    output logic                              clause_valid,
    input  logic                              clause_ready,
    output logic                              busy,
    output logic                              frame_err
`ifdef HCB_SEQ_PERF_EN
    ,
    output logic [31:0]                       frame_cnt,
    output logic [31:0]                       stall_cnt
`endif
);

    localparam int IDX_W = (PACKETS_NUM > 1) ? $clog2(PACKETS_NUM) : 1;
    localparam int DRN_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKETS_NUM - 1);

    typedef enum logic [1:0] {LOAD, DRAIN, OUT, FLUSH} state_t;

    state_t           state;
    logic [IDX_W-1:0] pkt_idx;
    logic [DRN_W-1:0] drain_cnt;
    logic             accept;

    assign s_axis_tready = (state == LOAD) || (state == FLUSH);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign busy          = !((state == LOAD) && (pkt_idx == '0));

    // Frame sequencing: load stages one-hot, wait for the chain to settle, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOAD;
            pkt_idx      <= '0;
            drain_cnt    <= '0;
            x            <= '0;
            valid        <= '0;
            clause_out   <= '0;
            clause_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            valid     <= '0;
            frame_err <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        x <= s_axis_tdata;
                        if (pkt_idx == LAST_IDX) begin
                            if (s_axis_tlast) begin
                                valid     <= PACKETS_NUM'(1) << pkt_idx;
                                drain_cnt <= DRN_W'(PIPE_LAT);
                                state     <= DRAIN;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= FLUSH;
                            end
                        end else if (s_axis_tlast) begin
                            frame_err <= 1'b1;
                            pkt_idx   <= '0;
                        end else begin
                            valid   <= PACKETS_NUM'(1) << pkt_idx;
                            pkt_idx <= pkt_idx + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        clause_out   <= partial_clause;
                        clause_valid <= 1'b1;
                        state        <= OUT;
                    end else begin
                        drain_cnt <= drain_cnt - DRN_W'(1);
                    end
                end
                OUT: begin
                    if (clause_ready) begin
                        clause_valid <= 1'b0;
                        pkt_idx      <= '0;
                        state        <= LOAD;
                    end
                end
                FLUSH: begin
                    if (accept && s_axis_tlast) begin
                        pkt_idx <= '0;
                        state   <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

`ifdef HCB_SEQ_PERF_EN
    // Count delivered results and cycles the result waits on downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            stall_cnt <= '0;
        end else if (state == OUT) begin
            if (clause_ready) frame_cnt <= frame_cnt + 32'd1;
            else stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hcb_frame_sequencer.sv
// tb_hcb_frame_sequencer: randomized frame stimulus checked against per-frame expectations derived from beat position.
module tb_hcb_frame_sequencer;
    localparam int PN = 13;
    localparam int CN = 200;
    localparam int DW = 32;
    localparam int PL = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] x;
    logic [PN-1:0] valid;
    logic [CN-1:0] partial_clause;
    logic [CN-1:0] clause_out;
    logic          clause_valid;
    logic          clause_ready;
    logic          busy;
    logic          frame_err;
`ifdef HCB_SEQ_PERF_EN
    logic [31:0]   frame_cnt;
    logic [31:0]   stall_cnt;
`endif

    int            total = 0;
    int            bad = 0;
    int            hs_model = 0;
    int            stall_model = 0;
    logic [CN-1:0] last_pc;

    hcb_frame_sequencer #(
        .PACKETS_NUM(PN), .CLAUSE_NUM(CN), .C_S00_AXIS_TDATA_WIDTH(DW), .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .x(x), .valid(valid), .partial_clause(partial_clause),
        .clause_out(clause_out), .clause_valid(clause_valid), .clause_ready(clause_ready),
        .busy(busy), .frame_err(frame_err)
`ifdef HCB_SEQ_PERF_EN
        , .frame_cnt(frame_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: fresh random chain output, remember what the DUT saw at the edge, settle.
    task automatic tick();
        logic [223:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        partial_clause = r[CN-1:0];
        @(posedge clk);
        last_pc = partial_clause;
        #1;
    endtask

    // Send a frame of len beats with tlast on the final beat; stall<0 picks a random backpressure length.
    task automatic frame(input int len, input bit gapped, input int stall);
        logic [DW-1:0] d;
        logic [CN-1:0] cap;
        bit            pulse;
        bit            err;
        int            st;
        for (int i = 0; i < len; i++) begin
            if (gapped) begin
                s_axis_tvalid = 1'b0;
                tick();
                chk("gap_valid", valid, 0);
            end
            d = $urandom();
            s_axis_tdata = d;
            s_axis_tvalid = 1'b1;
            s_axis_tlast = (i == len - 1);
            chk("tready", s_axis_tready, 1);
            tick();
            s_axis_tvalid = 1'b0;
            s_axis_tlast = 1'b0;
            pulse = (len == PN) || (i < len - 1 && i < PN - 1);
            err = (len < PN && i == len - 1) || (len > PN && i == PN - 1);
            chk("valid", valid, pulse ? (256'(1) << i) : 256'(0));
            if (pulse) chk("x", x, d);
            chk("frame_err", frame_err, err);
        end
        if (len == PN) begin
            chk("busy_drain", busy, 1);
            for (int c = 0; c <= PL; c++) begin
                chk("cv_early", clause_valid, 0);
                chk("tready_drain", s_axis_tready, 0);
                tick();
            end
            cap = last_pc;
            chk("cv_rise", clause_valid, 1);
            chk("clause_out", clause_out, cap);
            st = (stall < 0) ? $urandom_range(0, 5) : stall;
            clause_ready = 1'b0;
            for (int s = 0; s < st; s++) begin
                tick();
                chk("cv_hold", clause_valid, 1);
                chk("clause_hold", clause_out, cap);
                chk("tready_out", s_axis_tready, 0);
            end
            clause_ready = 1'b1;
            tick();
            clause_ready = 1'b0;
            hs_model++;
            stall_model += st;
            chk("cv_drop", clause_valid, 0);
            chk("tready_back", s_axis_tready, 1);
            chk("busy_idle", busy, 0);
        end else begin
            chk("busy_after_err", busy, 0);
            tick();
            chk("no_result", clause_valid, 0);
            chk("valid_idle", valid, 0);
        end
    endtask

    initial begin
        int len;
        rst = 1'b1;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        clause_ready = 1'b0;
        partial_clause = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_x", x, 0);
        chk("rst_valid", valid, 0);
        chk("rst_clause", clause_out, 0);
        chk("rst_cv", clause_valid, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tready", s_axis_tready, 1);

        frame(PN, 1'b0, 0);
        frame(PN, 1'b0, 5);
        frame(5, 1'b0, 0);
        frame(PN, 1'b0, -1);
        frame(16, 1'b0, 0);
        frame(PN, 1'b0, -1);

        for (int i = 0; i < 7; i++) begin
            s_axis_tdata = $urandom();
            s_axis_tvalid = 1'b1;
            tick();
        end
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hs_model = 0;
        stall_model = 0;
        chk("mid_rst_x", x, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_cv", clause_valid, 0);
        chk("mid_rst_clause", clause_out, 0);
        chk("mid_rst_err", frame_err, 0);
        chk("mid_rst_busy", busy, 0);
        frame(PN, 1'b0, 0);

        frame(PN, 1'b1, -1);

        for (int f = 0; f < 25; f++) begin
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 17)) : PN;
            frame(len, 1'(($urandom() & 1)), -1);
        end

`ifdef HCB_SEQ_PERF_EN
        chk("frame_cnt", frame_cnt, 256'(hs_model));
        chk("stall_cnt", stall_cnt, 256'(stall_model));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
